hdmi_mode_switcher: RTL
=======================

# hdmi_mode_switcher

Parametrised successor to the two-way PAL/NTSC TMDS selection. It selects one of `NUM_MODES` TMDS generator outputs (for example 480p, 576p or 480p-wide) on the shared pixel clock. Mode changes are glitch-free: `mode_sel` is debounced, the link carries DC-balanced control symbols while the target generator is held in reset, and streaming resumes only at the target generator's frame origin. The block sits between the per-mode `hdmi_output` instances and the serializer.

## Interface
- `NUM_MODES`, 2: number of generator inputs (≥2); `MODE_W = $clog2(NUM_MODES)` is derived.
- `NUM_CHANNELS`, 3: TMDS channels per generator.
- `CX_W`, 12 / `CY_W`, 11: coordinate widths.
- `STABLE_CYCLES`, 4: consecutive cycles `mode_sel` must hold before a request is accepted (≥1).
- `BLANK_CYCLES`, 1024: control-symbol cycles before the target generator is released (≥2).
- `RELEASE_TIMEOUT`, 1048576: maximum cycles waiting for the target frame origin.
- `clk_pixel` in 1: pixel clock. The single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `mode_sel` in MODE_W: requested mode, synchronous to `clk_pixel`.
- `tmds_in` in [NUM_MODES][NUM_CHANNELS][10]: encoded symbols per generator.
- `cx_in` in [NUM_MODES][CX_W] / `cy_in` in [NUM_MODES][CY_W]: generator coordinates.
- `tmds_out` out [NUM_CHANNELS][10]: registered symbols to the serializer.
- `cx` out CX_W / `cy` out CY_W: `cx_in[active_mode]` / `cy_in[active_mode]`, combinational.
- `active_mode` out MODE_W: mode currently routed, or targeted during a switch.
- `gen_reset` out NUM_MODES: active-high reset per generator.
- `switching` out 1: high in every state except STREAM.

## Operation
- `CTRL_SYM = 10'b1101010100`, the control symbol with C1C0 = 00. It is driven on all channels whenever the block is not in STREAM.
- **Debounce**
  - `cand` register plus `stab_cnt`. Any change of `mode_sel` loads `cand` and clears `stab_cnt`.
  - `req` is asserted when `stab_cnt` reaches `STABLE_CYCLES-1`, `cand < NUM_MODES` and `cand != active_mode`.
  - Out-of-range values never raise `req`.
- **FSM**
  - STREAM: `tmds_out <= tmds_in[active_mode]`. On `req`: `active_mode <= cand`, counter cleared, go to BLANK.
  - BLANK: `gen_reset` is all ones. The counter increments; at `BLANK_CYCLES-1` go to RELEASE with the counter cleared. On `req`: retarget, clear the counter, stay in BLANK.
  - RELEASE: `gen_reset[active_mode] = 0`, all others 1.
    - `cx_in[active_mode] == 0 && cy_in[active_mode] == 0` → STREAM.
    - Counter reaches `RELEASE_TIMEOUT-1` → BLANK (generator re-reset).
    - `req` → BLANK with the new target.
- **Simultaneous events:** in RELEASE, `req` wins over the origin match, and the origin match wins over timeout.
- **Reset values**
  - state BLANK, `active_mode` 0, counters 0, `cand` 0.
  - `gen_reset` all ones, `tmds_out` all `CTRL_SYM`, `switching` 1.
  - The power-up therefore brings mode 0 up through the normal sequence.
- **Mid-operation reset:** asserting `reset_n` at any time forces the reset values immediately. This is asynchronous assertion; release is synchronous to `clk_pixel`.
- In STREAM, `gen_reset` is all ones except `active_mode`, so idle generators stay parked.

## Timing
- Streaming latency: `tmds_in` → `tmds_out` is 1 cycle. `cx`/`cy` have 0 cycles.
- Request detect: `STABLE_CYCLES` cycles after `mode_sel` settles, `active_mode` changes and `tmds_out` is `CTRL_SYM` from the next edge.
- The first RELEASE cycle is exactly `BLANK_CYCLES` cycles after entering BLANK.
- The origin match is sampled on edge N. `tmds_out` carries `tmds_in[active_mode]` sampled at edge N+1, since the origin symbol itself is transmitted as `CTRL_SYM`.
- Every state transition and every output except `cx`/`cy` is registered. There are no combinational paths from `mode_sel`.

## Structure
- Shared `hdmi_pkg` holds:
  - `CTRL_SYM`;
  - the `switch_state_t` enum (STREAM, BLANK, RELEASE);
  - the mode index constants (`MODE_480P = 0`, `MODE_576P = 1`).
- Sub-module `mode_debounce`, parametrised by `WIDTH`, `STABLE_CYCLES` and `NUM_MODES`, outputs `cand`/`req`. The FSM, counter and muxes stay in the top module.

## Test plan
1. Reset, then `mode_sel = 0` and generator 0 reaching the origin after 5 cycles:
   - `tmds_out = CTRL_SYM` and `gen_reset = 2'b11` for 1024 cycles;
   - `gen_reset = 2'b10` in RELEASE;
   - after the origin match, STREAM with `tmds_out` equal to `tmds_in[0]` delayed 1 cycle, and `switching` = 0.
2. Streaming mode 0, `mode_sel` changes 0→1 and holds:
   - `active_mode = 1` and `CTRL_SYM` on the next edge after 4 stable cycles;
   - STREAM on `tmds_in[1]` after 1024 cycles plus the origin match.
3. A 3-cycle pulse `mode_sel = 1`, then back to 0 → no transition; `tmds_out` is uninterrupted.
4. Request 1, then request 0 at BLANK cycle 500 → `active_mode = 0` and the counter restarts. RELEASE begins 1024 cycles after the retarget.
5. `NUM_MODES = 3` with `mode_sel = 3` held for 100 cycles → no request; state remains STREAM.
6. Two cases:
   - `RELEASE_TIMEOUT = 16`, generator never at the origin → BLANK re-entered after 16 cycles with `gen_reset` all ones;
   - `reset_n` low mid-RELEASE → all outputs reach reset values with no clock edge.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI mode switcher: link control symbol,
// switcher state encoding and the canonical mode indices.
package hdmi_pkg;

  // Control symbol with C1C0 = 00; DC-balanced filler while no mode is live.
  localparam logic [9:0] CTRL_SYM = 10'b1101010100;

  typedef enum logic [1:0] {
    STREAM  = 2'd0,
    BLANK   = 2'd1,
    RELEASE = 2'd2
  } switch_state_t;

  localparam int MODE_480P = 0;
  localparam int MODE_576P = 1;

  // Larger of two sizes, used to size the shared blank/release counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mode_debounce.sv
// Debounces the requested mode: a request is raised only after mode_sel has
// held one in-range value for STABLE_CYCLES samples and it differs from the
// mode currently routed.
module mode_debounce #(
  parameter int WIDTH         = 1,
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_MODES     = 2
) (
  input  logic             clk_pixel,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] mode_sel,
  input  logic [WIDTH-1:0] active_mode,
  output logic [WIDTH-1:0] cand,
  output logic             req
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload the candidate on any change, otherwise count up and saturate.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (mode_sel != cand_q) begin
      cand_d = mode_sel;
      cnt_d  = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Candidate and stability counter registers.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cand = cand_q;
  // Driven from registers only, so mode_sel never reaches the FSM combinationally.
  assign req  = (cnt_q == CNT_LAST)
             && ({1'b0, cand_q} < (WIDTH + 1)'(NUM_MODES))
             && (cand_q != active_mode);

endmodule

// File: rtl/hdmi_mode_switcher.sv
// Glitch-free selector of one of NUM_MODES TMDS generators. A mode change
// blanks the link with control symbols, holds the target generator in reset,
// releases it and resumes streaming at the generator's frame origin.
import hdmi_pkg::*;

module hdmi_mode_switcher #(
  parameter int NUM_MODES       = 2,
  parameter int NUM_CHANNELS    = 3,
  parameter int CX_W            = 12,
  parameter int CY_W            = 11,
  parameter int STABLE_CYCLES   = 4,
  parameter int BLANK_CYCLES    = 1024,
  parameter int RELEASE_TIMEOUT = 1048576,
  localparam int MODE_W         = $clog2(NUM_MODES)
) (
  input  logic                                      clk_pixel,
  input  logic                                      reset_n,
  input  logic [MODE_W-1:0]                         mode_sel,
  input  logic [NUM_MODES-1:0][NUM_CHANNELS-1:0][9:0] tmds_in,
  input  logic [NUM_MODES-1:0][CX_W-1:0]            cx_in,
  input  logic [NUM_MODES-1:0][CY_W-1:0]            cy_in,
  output logic [NUM_CHANNELS-1:0][9:0]              tmds_out,
  output logic [CX_W-1:0]                           cx,
  output logic [CY_W-1:0]                           cy,
  output logic [MODE_W-1:0]                         active_mode,
  output logic [NUM_MODES-1:0]                      gen_reset,
  output logic                                      switching
);

  localparam int CNT_W = $clog2(max_int(BLANK_CYCLES, RELEASE_TIMEOUT));
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(RELEASE_TIMEOUT - 1);

  switch_state_t                  state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [MODE_W-1:0]              active_q, active_d;
  logic [NUM_CHANNELS-1:0][9:0]   tmds_q, tmds_d;
  logic [NUM_MODES-1:0]           gen_reset_q, gen_reset_d;
  logic                           switching_q, switching_d;
  logic [MODE_W-1:0]              cand;
  logic                           req;
  logic                           at_origin;

  mode_debounce #(
    .WIDTH         (MODE_W),
    .STABLE_CYCLES (STABLE_CYCLES),
    .NUM_MODES     (NUM_MODES)
  ) u_debounce (
    .clk_pixel   (clk_pixel),
    .reset_n     (reset_n),
    .mode_sel    (mode_sel),
    .active_mode (active_q),
    .cand        (cand),
    .req         (req)
  );

  assign at_origin = (cx_in[active_q] == '0) && (cy_in[active_q] == '0);

  // State, shared counter and routed-mode registers.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= BLANK;
      cnt_q    <= '0;
      active_q <= MODE_W'(MODE_480P);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  // Next state: a new request always wins, then origin match, then timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    case (state_q)
      STREAM: begin
        if (req) begin
          active_d = cand;
          cnt_d    = '0;
          state_d  = BLANK;
        end else begin
          state_d = STREAM;
        end
      end
      BLANK: begin
        if (req) begin
          active_d = cand;
          cnt_d    = '0;
        end else if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (req) begin
          active_d = cand;
          cnt_d    = '0;
          state_d  = BLANK;
        end else if (at_origin) begin
          cnt_d   = '0;
          state_d = STREAM;
        end else if (cnt_q == REL_LAST) begin
          cnt_d   = '0;
          state_d = BLANK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = BLANK;
      end
    endcase
  end

  // Output decode; generator resets track the upcoming state so they line up with it.
  always_comb begin
    gen_reset_d = '1;
    for (int m = 0; m < NUM_MODES; m++) begin
      if ((state_d != BLANK) && (active_d == MODE_W'(m))) begin
        gen_reset_d[m] = 1'b0;
      end else begin
        gen_reset_d[m] = 1'b1;
      end
    end
    switching_d = (state_d != STREAM);
    // The origin symbol itself still goes out as control; data follows one edge later.
    if (state_q == STREAM) begin
      tmds_d = tmds_in[active_q];
    end else begin
      tmds_d = {NUM_CHANNELS{CTRL_SYM}};
    end
  end

  // Output registers.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      tmds_q      <= {NUM_CHANNELS{CTRL_SYM}};
      gen_reset_q <= '1;
      switching_q <= 1'b1;
    end else begin
      tmds_q      <= tmds_d;
      gen_reset_q <= gen_reset_d;
      switching_q <= switching_d;
    end
  end

  assign tmds_out    = tmds_q;
  assign gen_reset   = gen_reset_q;
  assign switching   = switching_q;
  assign active_mode = active_q;
  assign cx          = cx_in[active_q];
  assign cy          = cy_in[active_q];

endmodule
